// File: rtl/mem_arbiter.sv
// Two-client cache-line arbiter onto a single memory port with in-order read routing.
// Build option: MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed dcache priority.
module mem_arbiter #(
    parameter int ADDR_BITS       = 28,
    parameter int DATA_BITS       = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   c0_req_valid,
    output logic                   c0_req_ready,
    input  logic [ADDR_BITS-1:0]   c0_req_addr,
    input  logic                   c0_req_rw,
    input  logic                   c0_req_data_valid,
    output logic                   c0_req_data_ready,
    input  logic [DATA_BITS-1:0]   c0_req_data_bits,
    input  logic [DATA_BITS/8-1:0] c0_req_data_mask,
    output logic                   c0_resp_valid,
    output logic [DATA_BITS-1:0]   c0_resp_data,
    input  logic                   c1_req_valid,
    output logic                   c1_req_ready,
    input  logic [ADDR_BITS-1:0]   c1_req_addr,
    input  logic                   c1_req_rw,
    input  logic                   c1_req_data_valid,
    output logic                   c1_req_data_ready,
    input  logic [DATA_BITS-1:0]   c1_req_data_bits,
    input  logic [DATA_BITS/8-1:0] c1_req_data_mask,
    output logic                   c1_resp_valid,
    output logic [DATA_BITS-1:0]   c1_resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int PTR_BITS = $clog2(MAX_OUTSTANDING);
    localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS+1)'(MAX_OUTSTANDING);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WDATA = 1'b1;

    logic [0:0]                 state;
    logic                       owner;
    logic [MAX_OUTSTANDING-1:0] ids;
    logic [PTR_BITS-1:0]        head;
    logic [PTR_BITS-1:0]        tail;
    logic [PTR_BITS:0]          count;

    logic sel, sel_valid, sel_rw, full, empty;
    logic req_fire, wr_path, dsel, data_fire, push, pop;

`ifdef MEM_ARB_RR_EN
    logic rr;

    // On a tie the preferred client wins; otherwise whichever is valid.
    always_comb begin
        sel = c1_req_valid;
        if (c0_req_valid && c1_req_valid)
            sel = rr;
    end

    // Preference alternates after every accepted request.
    always_ff @(posedge clk) begin
        if (reset)
            rr <= 1'b0;
        else if (req_fire)
            rr <= ~rr;
    end
`else
    // The dcache wins all ties.
    assign sel = c1_req_valid;
`endif

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign sel_valid = sel ? c1_req_valid : c0_req_valid;
    assign sel_rw    = sel ? c1_req_rw    : c0_req_rw;

    // Reads are held off while the ID FIFO cannot take another entry.
    assign mem_req_valid = (state == IDLE) && sel_valid && !(!sel_rw && full);
    assign mem_req_addr  = sel ? c1_req_addr : c0_req_addr;
    assign mem_req_rw    = sel_rw;

    assign req_fire     = mem_req_valid && mem_req_ready;
    assign c0_req_ready = req_fire && !sel;
    assign c1_req_ready = req_fire && sel;

    // Write data flows only for an accepted write or the locked owner.
    assign wr_path = (state == WDATA) || (req_fire && sel_rw);
    assign dsel    = (state == WDATA) ? owner : sel;

    assign mem_req_data_valid = wr_path &&
                                (dsel ? c1_req_data_valid : c0_req_data_valid);
    assign mem_req_data_bits  = dsel ? c1_req_data_bits : c0_req_data_bits;
    assign mem_req_data_mask  = dsel ? c1_req_data_mask : c0_req_data_mask;
    assign c0_req_data_ready  = wr_path && mem_req_data_ready && !dsel;
    assign c1_req_data_ready  = wr_path && mem_req_data_ready && dsel;

    assign data_fire = mem_req_data_valid && mem_req_data_ready;

    assign push = req_fire && !sel_rw;
    assign pop  = mem_resp_valid && !empty;

    assign c0_resp_valid = pop && !ids[head];
    assign c1_resp_valid = pop && ids[head];
    assign c0_resp_data  = mem_resp_data;
    assign c1_resp_data  = mem_resp_data;

    // Lock the data path to a writer whose beat did not arrive with its request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_fire && sel_rw && !data_fire) begin
                        state <= WDATA;
                        owner <= sel;
                    end
                end
                WDATA: begin
                    if (data_fire)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-ID storage; entries need no reset since count guards them.
    always_ff @(posedge clk) begin
        if (push)
            ids[tail] <= sel;
    end

    // In-order ID FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants, write
// beats and responses; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         c0_req_valid, c0_req_ready, c0_req_rw;
    logic [27:0]  c0_req_addr;
    logic         c0_req_data_valid, c0_req_data_ready;
    logic [127:0] c0_req_data_bits, c0_resp_data;
    logic [15:0]  c0_req_data_mask;
    logic         c0_resp_valid;
    logic         c1_req_valid, c1_req_ready, c1_req_rw;
    logic [27:0]  c1_req_addr;
    logic         c1_req_data_valid, c1_req_data_ready;
    logic [127:0] c1_req_data_bits, c1_resp_data;
    logic [15:0]  c1_req_data_mask;
    logic         c1_resp_valid;
    logic         mem_req_valid, mem_req_ready, mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic         mem_req_data_valid, mem_req_data_ready;
    logic [127:0] mem_req_data_bits, mem_resp_data;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready),
        .c0_req_addr(c0_req_addr), .c0_req_rw(c0_req_rw),
        .c0_req_data_valid(c0_req_data_valid),
        .c0_req_data_ready(c0_req_data_ready),
        .c0_req_data_bits(c0_req_data_bits),
        .c0_req_data_mask(c0_req_data_mask),
        .c0_resp_valid(c0_resp_valid), .c0_resp_data(c0_resp_data),
        .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready),
        .c1_req_addr(c1_req_addr), .c1_req_rw(c1_req_rw),
        .c1_req_data_valid(c1_req_data_valid),
        .c1_req_data_ready(c1_req_data_ready),
        .c1_req_data_bits(c1_req_data_bits),
        .c1_req_data_mask(c1_req_data_mask),
        .c1_resp_valid(c1_resp_valid), .c1_resp_data(c1_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    localparam int GR = 0;
    localparam int WD = 1;
    localparam int RS = 2;

    typedef struct {
        int           kind;
        int           cl;
        logic [127:0] a;
        logic [15:0]  m;
    } ev_t;

    ev_t sbq[$];
    int  nvec = 0;
    int  nerr = 0;

    localparam logic [127:0] PAT_A5 = {4{32'hA5A5_A5A5}};
    localparam logic [127:0] PAT_WR = 128'h1234_5678_9abc_def0_1234_5678_9abc_def0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic exp_ev(input int k, input int c, input logic [127:0] a,
                          input logic [15:0] m);
        ev_t e;
        e.kind = k;
        e.cl   = c;
        e.a    = a;
        e.m    = m;
        sbq.push_back(e);
    endtask

    task automatic take(input string nm, input int k, input int c,
                        input logic [127:0] a, input logic [15:0] m);
        ev_t e;
        if (sbq.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: unexpected event client %0d data %h", nm, c, a);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_kind"}, 128'(k), 128'(e.kind));
            chk({nm, "_client"}, 128'(c), 128'(e.cl));
            chk({nm, "_data"}, a, e.a);
            chk({nm, "_aux"}, 128'(m), 128'(e.m));
        end
    endtask

    // Monitor: every handshake the DUT presents must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (c0_req_ready && c1_req_ready)
                chk("dual_grant", 128'(1), 128'(0));
            if (c0_resp_valid && c1_resp_valid)
                chk("dual_resp", 128'(1), 128'(0));
            if (c0_req_ready || c1_req_ready)
                take("grant", GR, c1_req_ready ? 1 : 0,
                     128'(mem_req_addr), 16'(mem_req_rw));
            if (mem_req_data_valid && mem_req_data_ready)
                take("wbeat", WD, c1_req_data_ready ? 1 : 0,
                     mem_req_data_bits, mem_req_data_mask);
            if (c0_resp_valid || c1_resp_valid)
                take("resp", RS, c1_resp_valid ? 1 : 0,
                     c1_resp_valid ? c1_resp_data : c0_resp_data, 16'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        c0_req_valid = 0; c0_req_addr = '0; c0_req_rw = 0;
        c0_req_data_valid = 0; c0_req_data_bits = '0; c0_req_data_mask = '0;
        c1_req_valid = 0; c1_req_addr = '0; c1_req_rw = 0;
        c1_req_data_valid = 0; c1_req_data_bits = '0; c1_req_data_mask = '0;
        mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    task automatic rd0(input logic [27:0] a);
        c0_req_valid = 1; c0_req_addr = a; c0_req_rw = 0;
    endtask

    int win[4];

    initial begin
        reset = 1;
        mem_req_ready = 1;
        mem_req_data_ready = 1;
        idle_in();
        repeat (2) tick();
        reset = 0;
        #2;
        chk("rst_mem_valid", 128'(mem_req_valid), 0);
        chk("rst_c0_ready", 128'(c0_req_ready), 0);
        chk("rst_c1_ready", 128'(c1_req_ready), 0);
        chk("rst_data_valid", 128'(mem_req_data_valid), 0);
        chk("rst_dready", 128'({c0_req_data_ready, c1_req_data_ready}), 0);
        chk("rst_resp", 128'({c0_resp_valid, c1_resp_valid}), 0);
        chk("rst_addr_rw", 128'({mem_req_addr, mem_req_rw}), 0);

        // Single read, single response to c0.
        tick(); rd0(28'h10); exp_ev(GR, 0, 128'h10, 16'h0);
        #2 chk("t1_c1_ready", 128'(c1_req_ready), 0);
        tick(); idle_in();
        mem_resp_valid = 1; mem_resp_data = PAT_A5;
        exp_ev(RS, 0, PAT_A5, 16'h0);
        #2 chk("t1_c1_resp", 128'(c1_resp_valid), 0);
        tick(); idle_in();

        // Both clients read on every cycle.
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            win[i] = (i % 2 == 0) ? 1 : 0;
`else
            win[i] = 1;
`endif
            tick();
            rd0(28'h10);
            c1_req_valid = 1; c1_req_addr = 28'h20; c1_req_rw = 0;
            exp_ev(GR, win[i], win[i] ? 128'h20 : 128'h10, 16'h0);
        end
        tick(); idle_in();
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_resp_valid = 1; mem_resp_data = 128'(i + 100);
            exp_ev(RS, win[i], 128'(i + 100), 16'h0);
        end
        tick(); idle_in();

        // Fill the FIFO, then a read stalls while a write goes through.
        for (int i = 0; i < 4; i++) begin
            tick(); rd0(28'h40 + 28'(i)); exp_ev(GR, 0, 128'h40 + 128'(i), 16'h0);
        end
        tick(); rd0(28'h50);
        #2 chk("full_mem_valid", 128'(mem_req_valid), 0);
        chk("full_c0_ready", 128'(c0_req_ready), 0);
        tick(); rd0(28'h50);
        c1_req_valid = 1; c1_req_addr = 28'h30; c1_req_rw = 1;
        c1_req_data_valid = 1; c1_req_data_bits = PAT_WR;
        c1_req_data_mask = 16'hFFFF;
        exp_ev(GR, 1, 128'h30, 16'h1);
        exp_ev(WD, 1, PAT_WR, 16'hFFFF);
        #2 chk("full_wr_c0_ready", 128'(c0_req_ready), 0);

        // Full FIFO with push and pop together: push is refused.
        tick(); idle_in(); rd0(28'h60);
        mem_resp_valid = 1; mem_resp_data = 128'h200;
        exp_ev(RS, 0, 128'h200, 16'h0);
        #2 chk("pp_c0_ready", 128'(c0_req_ready), 0);
        tick(); mem_resp_valid = 0; rd0(28'h60);
        exp_ev(GR, 0, 128'h60, 16'h0);
        tick(); rd0(28'h61);
        #2 chk("refull_c0_ready", 128'(c0_req_ready), 0);
        for (int i = 0; i < 4; i++) begin
            tick(); idle_in();
            mem_resp_valid = 1; mem_resp_data = 128'(i + 300);
            exp_ev(RS, 0, 128'(i + 300), 16'h0);
        end
        tick(); idle_in();

        // Write whose data beat lags the request.
        tick();
        c1_req_valid = 1; c1_req_addr = 28'h30; c1_req_rw = 1;
        exp_ev(GR, 1, 128'h30, 16'h1);
        #2 chk("wd_early_dvalid", 128'(mem_req_data_valid), 0);
        for (int i = 0; i < 2; i++) begin
            tick(); c1_req_valid = 0; rd0(28'h70);
            c0_req_data_valid = 1; c0_req_data_bits = PAT_A5;
            #2 chk("wd_mem_valid", 128'(mem_req_valid), 0);
            chk("wd_c0_ready", 128'(c0_req_ready), 0);
            chk("wd_nonowner", 128'(mem_req_data_valid), 0);
        end
        tick(); c0_req_data_valid = 0;
        c1_req_data_valid = 1; c1_req_data_bits = PAT_WR;
        c1_req_data_mask = 16'hFFFF;
        exp_ev(WD, 1, PAT_WR, 16'hFFFF);
        #2 chk("wd_beat_c0_ready", 128'(c0_req_ready), 0);
        tick(); c1_req_data_valid = 0;
        exp_ev(GR, 0, 128'h70, 16'h0);
        tick(); idle_in();
        mem_resp_valid = 1; mem_resp_data = 128'h400;
        exp_ev(RS, 0, 128'h400, 16'h0);
        tick(); idle_in();

        // Reset with two reads outstanding and a write locked.
        tick(); rd0(28'h80); exp_ev(GR, 0, 128'h80, 16'h0);
        tick(); rd0(28'h81); exp_ev(GR, 0, 128'h81, 16'h0);
        tick(); idle_in();
        c1_req_valid = 1; c1_req_addr = 28'h90; c1_req_rw = 1;
        exp_ev(GR, 1, 128'h90, 16'h1);
        tick(); idle_in(); reset = 1;
        tick(); reset = 0;
        c1_req_data_valid = 1; c1_req_data_bits = PAT_WR;
        #2 chk("prst_dvalid", 128'(mem_req_data_valid), 0);
        chk("prst_c1_dready", 128'(c1_req_data_ready), 0);
        for (int i = 0; i < 2; i++) begin
            tick(); idle_in();
            mem_resp_valid = 1; mem_resp_data = 128'h500;
            #2 chk("prst_drop", 128'({c0_resp_valid, c1_resp_valid}), 0);
        end
        tick(); idle_in(); rd0(28'hA0);
        exp_ev(GR, 0, 128'hA0, 16'h0);
        tick(); idle_in();
        tick(); mem_resp_valid = 1; mem_resp_data = 128'h600;
        exp_ev(RS, 0, 128'h600, 16'h0);
        tick(); idle_in();
        tick();

        chk("sb_leftover", 128'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches.
- Merges their two cache-line memory interfaces (28-bit line address, 128-bit beats) onto the single external memory port.
- Arbitrates requests and holds the grant through a write's data beat.
- Tracks outstanding reads in an in-order ID FIFO, so each memory response is steered back to the client that issued it.

Parameters:
- ADDR_BITS, 28, line-granular address width (word address bits above the 4-word beat offset).
- DATA_BITS, 128, memory beat width; mask width is DATA_BITS/8.
- MAX_OUTSTANDING, 4, depth of the read-ID FIFO; power of two, at least 2.

Ports:
- clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
- reset  input  1  synchronous active-high reset.
- cN_req_valid  input  1  client N request valid, where N is 0 (icache) or 1 (dcache); applies to every cN_ line.
- cN_req_ready  output  1  client N request accepted this cycle.
- cN_req_addr  input  ADDR_BITS  client N line address.
- cN_req_rw  input  1  1 = write, 0 = read.
- cN_req_data_valid  input  1  client N write data valid.
- cN_req_data_ready  output  1  client N write data accepted.
- cN_req_data_bits  input  DATA_BITS  client N write data.
- cN_req_data_mask  input  DATA_BITS/8  client N byte mask.
- cN_resp_valid  output  1  read response for client N.
- cN_resp_data  output  DATA_BITS  response data; wired straight from mem_resp_data to both clients.
- mem_req_valid  output  1  request to memory.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  ADDR_BITS  muxed address.
- mem_req_rw  output  1  muxed rw.
- mem_req_data_valid  output  1  write data valid.
- mem_req_data_ready  input  1  memory accepts data.
- mem_req_data_bits  output  DATA_BITS  muxed write data.
- mem_req_data_mask  output  DATA_BITS/8  muxed mask.
- mem_resp_valid  input  1  read beat returned; responses arrive in request order.
- mem_resp_data  input  DATA_BITS  read beat.

Behaviour:
- States: IDLE and WDATA.
- Reset: state=IDLE, FIFO empty (count=0), rr pointer=0.
  - All outputs are 0 except the data buses, which follow their muxes.
- IDLE selection:
  - sel = the winner among valid clients.
  - If exactly one client is valid, it wins.
  - If both are valid, fixed priority with client 1 winning (see optional feature).
- IDLE request path:
  - mem_req_valid = selected client's valid, forced to 0 when the selected request is a read and count==MAX_OUTSTANDING.
  - addr and rw are muxed from sel.
  - cN_req_ready = mem_req_ready & mem_req_valid & (sel==N). No combinational path from cN_req_ready back into the selection.
- Read accept (rw=0 handshake): push sel into the FIFO.
  - A pop in the same cycle does not enable a push when the FIFO is full; readiness uses count before the update.
- Write accept (rw=1 handshake):
  - Data path is muxed from sel; mem_req_data_valid = cN_req_data_valid of sel, and cN_req_data_ready = mem_req_data_ready for sel only.
  - If the data handshake completes in the same cycle as the request, stay in IDLE.
  - Otherwise latch owner=sel and go to WDATA.
- WDATA:
  - mem_req_valid=0; both cN_req_ready=0.
  - Data path is muxed from owner.
  - Return to IDLE on the data handshake.
  - Data from a non-owner is never forwarded.
- Responses:
  - cN_resp_valid = mem_resp_valid & (count!=0) & (head==N); zero-cycle pass-through.
  - Pop on mem_resp_valid when not empty.
  - mem_resp_valid while the FIFO is empty is dropped; neither resp_valid is asserted.
- Simultaneous events:
  - Push and pop in one cycle leaves count unchanged.
  - head/tail pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation: the FIFO and WDATA state are discarded, and responses to pre-reset reads are dropped as empty-FIFO responses.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration with a 1-bit rr pointer naming the preferred client.
  - When both clients are valid, the preferred client wins.
  - The pointer flips to the other client after any request handshake.
- Undefined: fixed priority, client 1 (dcache) always wins ties; no rr register.

Test Plan:
- Reset, then c0 read addr 0x0000010 with mem_req_ready=1 → c0_req_ready=1 that cycle, count=1; mem_resp_valid with data 0xA5…A5 → c0_resp_valid=1, c1_resp_valid=0, count=0.
- c0 and c1 both read (0x10, 0x20) each cycle for 4 cycles, ready=1 → without the macro: four c1 grants and c0 starved; with MEM_ARB_RR_EN: grants alternate 1,0,1,0. Responses are then returned in order and routed 1,0,1,0.
- Issue 4 reads with no responses → count=4, a 5th read stalls (c0_req_ready=0, mem_req_valid=0) while a c1 write is still granted.
- c1 write addr 0x30 with data_valid low for 3 cycles → state is WDATA and a c0 read is blocked. Raise data_valid with mem_req_data_ready=1 → data 0x1234…, mask 0xFFFF forwarded, return to IDLE, c0 read granted next cycle.
- Full FIFO plus push and pop in the same cycle → push refused, count 4→3. Next cycle the push succeeds and count=4.
- Reset asserted with count=2 and state=WDATA → next cycle IDLE, count=0; a later mem_resp_valid produces no resp_valid.
